// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package seg7_pkg;

    localparam int IDX_W = 2;
    localparam int NDIG  = 4;

    // Active-high {g,f,e,d,c,b,a} patterns, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

    function automatic logic [NDIG-1:0] an_off(input bit active_low);
        return active_low ? {NDIG{1'b1}} : {NDIG{1'b0}};
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Purpose: hex nibble to active-high seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input nibble.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Purpose: latch a 16-bit hex word and scan it onto a 4-digit multiplexed display.
// Latency: load visible on an/seg/dp two edges after the strobe; outputs registered.
// Backpressure: none; load is a strobe that is always accepted, scanning free-runs.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50_000,
    parameter int DEAD       = 2,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [15:0]      din,
    input  logic [3:0]       dp_in,
    input  logic             blank,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [IDX_W-1:0] digit_idx
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_DEAD = CW'(DEAD);
    localparam logic [3:0]     AN_INACT = an_off(ACTIVE_LOW);
    localparam logic [6:0]     SEG_INACT = seg_off(ACTIVE_LOW);

    logic [CW-1:0] cnt;
    logic [15:0]   data_r;
    logic [3:0]    dp_r;

    logic [3:0]    nib;
    logic [6:0]    seg_hi;
    logic [3:0]    an_hot;
    logic          lz3, lz2, lz1;
    logic [3:0]    lz;
    logic          lit;

    assign nib = data_r[{digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nib (nib),
        .seg (seg_hi)
    );

    // A digit goes dark only while it and every digit to its left show a bare zero.
    assign lz3 = LZ_BLANK && (data_r[15:12] == 4'h0) && !dp_r[3];
    assign lz2 = lz3 && (data_r[11:8] == 4'h0) && !dp_r[2];
    assign lz1 = lz2 && (data_r[7:4]  == 4'h0) && !dp_r[1];
    assign lz  = {lz3, lz2, lz1, 1'b0};

    assign an_hot = 4'b0001 << digit_idx;
    assign lit    = (cnt >= CNT_DEAD) && !blank && !lz[digit_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            digit_idx <= '0;
            data_r    <= '0;
            dp_r      <= '0;
            an        <= AN_INACT;
            seg       <= SEG_INACT;
            dp        <= ACTIVE_LOW;
        end else begin
            if (load) begin
                data_r <= din;
                dp_r   <= dp_in;
            end

            if (cnt == CNT_LAST) begin
                cnt       <= '0;
                digit_idx <= digit_idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (lit) begin
                an  <= an_hot ^ {4{ACTIVE_LOW}};
                seg <= seg_hi ^ {7{ACTIVE_LOW}};
                dp  <= dp_r[digit_idx] ^ ACTIVE_LOW;
            end else begin
                an  <= AN_INACT;
                seg <= SEG_INACT;
                dp  <= ACTIVE_LOW;
            end
        end
    end

endmodule
